// File: rtl/uart_cmd_ctrl.sv
// rtl/uart_cmd_ctrl.sv - UART 3-byte {opcode, addr, data} command decoder driving a register bank.
// Optional macro UART_CMD_ACK_EN: reply 0xA5 to WRITE and 0xEE to unknown opcodes.
module uart_cmd_ctrl #(
  parameter logic [31:0] TIMEOUT_CYC = 32'd50000,
  parameter int unsigned ADDR_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_done,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  output logic              reg_we,
  output logic              reg_re,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [7:0] OP_WRITE = 8'h01;
  localparam logic [7:0] OP_READ  = 8'h02;
`ifdef UART_CMD_ACK_EN
  localparam logic [7:0] ACK_WRITE   = 8'hA5;
  localparam logic [7:0] ACK_UNKNOWN = 8'hEE;
`endif

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    EXEC,
    RD_WAIT,
    TX_START,
    TX_WAIT
  } state_t;

  state_t            state_q, state_d;
  logic [31:0]       cnt_q, cnt_d;
  logic [7:0]        opcode_q, opcode_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        data_q, data_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_wr_q, tx_wr_d;
  logic              reg_we_q, reg_we_d;
  logic              reg_re_q, reg_re_d;
  logic              err_q, err_d;

  logic [ADDR_W+7:0] addr_ext;
  logic              timeout;
  logic              exec_phase;

  // Zero-extend before slicing so any ADDR_W picks the low bits of the address byte.
  assign addr_ext   = {{ADDR_W{1'b0}}, rx_data};
  assign timeout    = (cnt_q == TIMEOUT_CYC - 32'd1);
  assign exec_phase = (state_q == EXEC) || (state_q == RD_WAIT) ||
                      (state_q == TX_START) || (state_q == TX_WAIT);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    opcode_d  = opcode_q;
    addr_d    = addr_q;
    data_d    = data_q;
    tx_data_d = tx_data_q;
    tx_wr_d   = 1'b0;
    reg_we_d  = 1'b0;
    reg_re_d  = 1'b0;
    // A byte arriving while a command is being executed is an overrun and is dropped.
    err_d     = rx_done && exec_phase;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rx_done) begin
          opcode_d = rx_data;
          state_d  = GET_ADDR;
        end
      end

      GET_ADDR: begin
        if (rx_done) begin
          addr_d  = addr_ext[ADDR_W-1:0];
          cnt_d   = '0;
          state_d = GET_DATA;
        end else if (timeout) begin
          cnt_d    = '0;
          opcode_d = '0;
          addr_d   = '0;
          data_d   = '0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      GET_DATA: begin
        if (rx_done) begin
          data_d  = rx_data;
          cnt_d   = '0;
          state_d = EXEC;
          // Strobes are registered so they land in the EXEC cycle.
          case (opcode_q)
            OP_WRITE: reg_we_d = 1'b1;
            OP_READ:  reg_re_d = 1'b1;
            default:  err_d    = 1'b1;
          endcase
        end else if (timeout) begin
          cnt_d    = '0;
          opcode_d = '0;
          addr_d   = '0;
          data_d   = '0;
          err_d    = 1'b1;
          state_d  = IDLE;
        end else begin
          cnt_d = cnt_q + 32'd1;
        end
      end

      EXEC: begin
        if (opcode_q == OP_READ) begin
          state_d = RD_WAIT;
        end else begin
`ifdef UART_CMD_ACK_EN
          tx_data_d = (opcode_q == OP_WRITE) ? ACK_WRITE : ACK_UNKNOWN;
          tx_wr_d   = 1'b1;
          state_d   = TX_START;
`else
          state_d   = IDLE;
`endif
        end
      end

      RD_WAIT: begin
        tx_data_d = reg_rdata;
        tx_wr_d   = 1'b1;
        state_d   = TX_START;
      end

      TX_START: begin
        state_d = TX_WAIT;
      end

      TX_WAIT: begin
        if (tx_done) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      opcode_q  <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      tx_data_q <= '0;
      tx_wr_q   <= 1'b0;
      reg_we_q  <= 1'b0;
      reg_re_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      opcode_q  <= opcode_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      tx_data_q <= tx_data_d;
      tx_wr_q   <= tx_wr_d;
      reg_we_q  <= reg_we_d;
      reg_re_q  <= reg_re_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert ($onehot0({reg_we_q, reg_re_q, tx_wr_q}));
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_wr     = tx_wr_q;
  assign reg_addr  = addr_q;
  assign reg_wdata = data_q;
  assign reg_we    = reg_we_q;
  assign reg_re    = reg_re_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb/tb_uart_cmd_ctrl.sv - scoreboard bench for uart_cmd_ctrl (default build, short timeout).
module tb_uart_cmd_ctrl;

  localparam int TO = 20;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       rx_done = 1'b0;
  logic [7:0] tx_data;
  logic       tx_wr;
  logic       tx_done = 1'b0;
  logic [7:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_we;
  logic       reg_re;
  logic [7:0] reg_rdata = 8'h00;
  logic       busy;
  logic       err;

  int cyc = 0;
  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [7:0]  addr;
    logic [7:0]  data;
    logic [31:0] cyc;
  } ev_t;

  ev_t q_we[$];
  ev_t q_re[$];
  ev_t q_tx[$];
  ev_t q_err[$];

  logic [7:0] mem [256];

  uart_cmd_ctrl #(.TIMEOUT_CYC(32'd20), .ADDR_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .tx_data   (tx_data),
    .tx_wr     (tx_wr),
    .tx_done   (tx_done),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_we    (reg_we),
    .reg_re    (reg_re),
    .reg_rdata (reg_rdata),
    .busy      (busy),
    .err       (err)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Register bank model: read data appears one cycle after reg_re.
  always @(posedge clk) begin
    if (cyc == 0) begin
      for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
      mem[5] <= 8'h6B;
    end else begin
      if (reg_we) mem[reg_addr] <= reg_wdata;
      if (reg_re) reg_rdata <= mem[reg_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mon_event(input string name, input int kind, input ev_t act);
    ev_t exp;
    int  n;
    case (kind)
      0:       n = q_we.size();
      1:       n = q_re.size();
      2:       n = q_tx.size();
      default: n = q_err.size();
    endcase
    checks++;
    if (n == 0) begin
      errors++;
      $display("FAIL %s unexpected: addr=%02h data=%02h cyc=%0d, expected no event",
               name, act.addr, act.data, act.cyc);
    end else begin
      case (kind)
        0:       exp = q_we.pop_front();
        1:       exp = q_re.pop_front();
        2:       exp = q_tx.pop_front();
        default: exp = q_err.pop_front();
      endcase
      if (act !== exp) begin
        errors++;
        $display("FAIL %s: got addr=%02h data=%02h cyc=%0d, expected addr=%02h data=%02h cyc=%0d",
                 name, act.addr, act.data, act.cyc, exp.addr, exp.data, exp.cyc);
      end
    end
  endtask

  always @(negedge clk) begin
    if (reg_we) mon_event("reg_we", 0, '{addr: reg_addr, data: reg_wdata, cyc: cyc});
    if (reg_re) mon_event("reg_re", 1, '{addr: reg_addr, data: 8'h00, cyc: cyc});
    if (tx_wr)  mon_event("tx_wr", 2, '{addr: 8'h00, data: tx_data, cyc: cyc});
    if (err)    mon_event("err", 3, '{addr: 8'h00, data: 8'h00, cyc: cyc});
    if (reg_we || reg_re || tx_wr)
      check("strobe_exclusive", int'(reg_we) + int'(reg_re) + int'(tx_wr), 1);
  end

  task automatic send_byte(input logic [7:0] b, output int t);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    t = cyc;
    @(posedge clk);
    #1;
    rx_done = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] op, input logic [7:0] a, input logic [7:0] d,
                            output int t3);
    int t;
    send_byte(op, t);
    send_byte(a, t);
    send_byte(d, t3);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_tx_done(input string name, input logic exp_busy);
    @(negedge clk);
    tx_done = 1'b1;
    check({name, "_busy_at_tx_done"}, 32'(busy), 32'(exp_busy));
    @(posedge clk);
    #1;
    tx_done = 1'b0;
    @(negedge clk);
    check({name, "_busy_after_tx_done"}, 32'(busy), 32'd0);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {3'b000, tx_data, tx_wr, reg_addr, reg_wdata, reg_we, reg_re, busy, err}, 32'd0);
  endtask

  initial begin
    int t;
    int t2;

    idle(3);
    check_all_zero("outputs_in_reset");
    rst_n = 1'b1;
    idle(2);
    check_all_zero("outputs_after_reset");

    // WRITE 0x00 <= 0xA1, no reply
    send_frame(8'h01, 8'h00, 8'hA1, t);
    q_we.push_back('{addr: 8'h00, data: 8'hA1, cyc: 32'(t + 1)});
    idle(5);

    // READ 0x00 -> reply 0xA1 three cycles after the last byte
    send_frame(8'h02, 8'h00, 8'h00, t);
    q_re.push_back('{addr: 8'h00, data: 8'h00, cyc: 32'(t + 1)});
    q_tx.push_back('{addr: 8'h00, data: 8'hA1, cyc: 32'(t + 3)});
    idle(4);
    check("read_tx_data_held", 32'(tx_data), 32'h A1);
    pulse_tx_done("read", 1'b1);

    // Partial frame then silence -> timeout error
    send_byte(8'h01, t);
    send_byte(8'h00, t2);
    q_err.push_back('{addr: 8'h00, data: 8'h00, cyc: 32'(t2 + TO + 1)});
    idle(TO + 4);
    check("idle_after_timeout", 32'(busy), 32'd0);
    send_frame(8'h02, 8'h05, 8'h00, t);
    q_re.push_back('{addr: 8'h05, data: 8'h00, cyc: 32'(t + 1)});
    q_tx.push_back('{addr: 8'h00, data: 8'h6B, cyc: 32'(t + 3)});
    idle(4);
    pulse_tx_done("read5", 1'b1);

    // Unknown opcode
    send_frame(8'h7F, 8'h00, 8'h00, t);
    q_err.push_back('{addr: 8'h00, data: 8'h00, cyc: 32'(t + 1)});
    idle(5);
    check("idle_after_unknown", 32'(busy), 32'd0);

    // Overrun byte during TX_WAIT of a READ
    send_frame(8'h02, 8'h00, 8'h00, t);
    q_re.push_back('{addr: 8'h00, data: 8'h00, cyc: 32'(t + 1)});
    q_tx.push_back('{addr: 8'h00, data: 8'hA1, cyc: 32'(t + 3)});
    idle(3);
    send_byte(8'h55, t2);
    q_err.push_back('{addr: 8'h00, data: 8'h00, cyc: 32'(t2 + 1)});
    idle(2);
    check("overrun_tx_data_unchanged", 32'(tx_data), 32'hA1);
    pulse_tx_done("overrun", 1'b1);
    send_frame(8'h01, 8'h07, 8'h99, t);
    q_we.push_back('{addr: 8'h07, data: 8'h99, cyc: 32'(t + 1)});
    idle(3);

    // Byte landing on the timeout cycle wins over the timeout
    send_byte(8'h01, t);
    idle(TO - 1);
    send_byte(8'h09, t2);
    send_byte(8'h42, t2);
    q_we.push_back('{addr: 8'h09, data: 8'h42, cyc: 32'(t2 + 1)});
    idle(3);

    // Reset while in GET_DATA, then a stale tx_done must be ignored
    send_byte(8'h01, t);
    send_byte(8'h03, t);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check_all_zero("outputs_after_midframe_reset");
    pulse_tx_done("stale", 1'b0);
    send_frame(8'h01, 8'h03, 8'h3C, t);
    q_we.push_back('{addr: 8'h03, data: 8'h3C, cyc: 32'(t + 1)});
    idle(TO + 5);

    check("pending_reg_we", 32'(q_we.size()), 32'd0);
    check("pending_reg_re", 32'(q_re.size()), 32'd0);
    check("pending_tx_wr", 32'(q_tx.size()), 32'd0);
    check("pending_err", 32'(q_err.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_cmd_ctrl.md
UART_CMD_CTRL -- requirements
Module: uart_cmd_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 32'd50000, meaning the inter-byte timeout in clk cycles while a frame is partially received.
REQ-002 SHALL have parameter ADDR_W, default 8, meaning the register address width; only the low ADDR_W bits of the address byte are used.
REQ-003 SHALL have port clk  input  1  system clock; all logic is on the rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rx_data  input  8  received byte from the UART transceiver.
REQ-006 SHALL have port rx_done  input  1  one-cycle pulse; rx_data is valid in that cycle.
REQ-007 SHALL have port tx_data  output  8  byte to transmit.
REQ-008 SHALL have port tx_wr  output  1  one-cycle transmit start pulse.
REQ-009 SHALL have port tx_done  input  1  one-cycle pulse when the transceiver finishes a byte.
REQ-010 SHALL have port reg_addr  output  ADDR_W  register bank address.
REQ-011 SHALL have port reg_wdata  output  8  register write data.
REQ-012 SHALL have port reg_we  output  1  one-cycle register write strobe.
REQ-013 SHALL have port reg_re  output  1  one-cycle register read strobe.
REQ-014 SHALL have port reg_rdata  input  8  read data, valid exactly one cycle after reg_re.
REQ-015 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-016 SHALL have port err  output  1  one-cycle pulse on timeout, overrun or an unknown opcode.

Function
REQ-017 SHALL use the frame format: 3 bytes {opcode, addr, data}; opcode 0x01 = WRITE, 0x02 = READ (data byte ignored); any other opcode is unknown.
REQ-018 SHALL implement the states IDLE, GET_ADDR, GET_DATA, EXEC, RD_WAIT, TX_START and TX_WAIT.
REQ-019 SHALL make these transitions:
  - IDLE to GET_ADDR on rx_done.
  - GET_ADDR to GET_DATA on rx_done.
  - GET_DATA to EXEC on rx_done.
REQ-020 SHALL, for WRITE, take EXEC to IDLE: reg_we is high for one cycle, one cycle after the third rx_done, with reg_addr/reg_wdata from the frame.
REQ-021 SHALL, for READ, take EXEC to RD_WAIT to TX_START:
  - reg_re is high one cycle after the third rx_done.
  - reg_rdata is captured in RD_WAIT.
  - tx_wr pulses for one cycle in TX_START, with tx_data = the captured byte, 3 cycles after the third rx_done.
REQ-022 SHALL go from TX_WAIT to IDLE on tx_done; tx_data is held stable from tx_wr until tx_done.
REQ-023 SHALL, for an unknown opcode, pulse err in EXEC, issue no reg strobe and return to IDLE (unless UART_CMD_ACK_EN is defined).
REQ-024 SHALL run an inter-byte counter in GET_ADDR/GET_DATA that clears on each rx_done; when it reaches TIMEOUT_CYC, the state returns to IDLE, err pulses and the partial frame is discarded.
REQ-025 SHALL give rx_done priority over timeout expiry when both occur in the same cycle.
REQ-026 SHALL treat rx_done in EXEC/RD_WAIT/TX_START/TX_WAIT as overrun: the byte is dropped, err pulses, and the current operation completes normally.
REQ-027 SHALL ignore tx_done outside TX_WAIT.
REQ-028 SHALL never assert reg_we, reg_re and tx_wr in the same cycle.

Reset
REQ-029 SHALL, while rst_n is low at a clk edge, force the state to IDLE, clear the timeout counter and the frame registers, and drive tx_data=0, tx_wr=0, reg_addr=0, reg_wdata=0, reg_we=0, reg_re=0, busy=0, err=0.
REQ-030 SHALL, on reset mid-frame or mid-transmit, abandon the operation with no strobe issued, and ignore the pending tx_done after reset.

Configuration
REQ-031 SHALL, when macro UART_CMD_ACK_EN is defined, reply to WRITE with byte 0xA5 and to an unknown opcode with 0xEE, both via TX_START/TX_WAIT; the reply tx_wr occurs 2 cycles after the third rx_done.
REQ-032 SHALL, when UART_CMD_ACK_EN is undefined, send no reply for WRITE or unknown opcodes; READ behaviour is identical in both builds.

Verification
REQ-033 SHALL cover: reset release, then frame 01 00 A1 -> one-cycle reg_we with reg_addr=0x00 and reg_wdata=0xA1; no tx_wr (macro off).
REQ-034 SHALL cover: frame 01 00 A1 then 02 00 00, with a register model returning the stored value -> reg_re, then tx_wr with tx_data=0xA1 3 cycles after the third rx_done; busy drops the cycle after tx_done.
REQ-035 SHALL cover: bytes 01 00, then silence for TIMEOUT_CYC cycles -> err pulse, state IDLE, no reg_we; a following 02 05 00 reads address 0x05.
REQ-036 SHALL cover: frame 7F 00 00 -> err pulse, no strobes; with UART_CMD_ACK_EN defined, tx_data=0xEE is sent instead.
REQ-037 SHALL cover: an extra rx_done (byte 0x55) during TX_WAIT of a READ -> err pulse, reply byte unchanged, and the next frame is parsed correctly from its opcode.
REQ-038 SHALL cover: rst_n low for one cycle while in GET_DATA -> all outputs 0 and state IDLE; a following 01 03 3C writes 0x3C to address 0x03.
